// File: rtl/mem_stage_pipe_if.sv
// Data-memory port of the MEM stage: one request/acknowledge handshake.
// The pipeline drives the request side (master); the memory answers (slave).
interface mem_stage_pipe_if #(
  parameter int unsigned XLEN = 32
);

  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_ack;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_ack
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_ack
  );

endinterface

// File: rtl/mem_stage_pipe.sv
// EX/MEM and MEM/WB pipeline registers with the MEM-stage data-memory handshake.
// A memory op sits in EX/MEM until the memory acknowledges it; meanwhile EX is
// back-pressured and MEM/WB receives bubbles, so every op writes back exactly once.
module mem_stage_pipe #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,

  // EX stage
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_reg_write,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic [XLEN-1:0]       ex_alu_result,
  input  logic [XLEN-1:0]       ex_store_data,
  output logic                  ex_ready,

  // Data memory
  mem_stage_pipe_if.master      dmem,

  // Forwarding / hazard taps
  output logic                  EX_MEM_regWrite,
  output logic [REG_ADDR_W-1:0] EX_MEM_rd,
  output logic [XLEN-1:0]       EX_MEM_fwd_data,

  // Writeback
  output logic                  MEM_WB_regWrite,
  output logic [REG_ADDR_W-1:0] MEM_WB_rd,
  output logic [XLEN-1:0]       MEM_WB_data
);

  typedef enum logic [0:0] {
    StIdle,
    StAccess
  } state_e;

  state_e state_q, state_d;

  // EX/MEM entry
  logic                  exm_valid_q,     exm_valid_d;
  logic [REG_ADDR_W-1:0] exm_rd_q,        exm_rd_d;
  logic                  exm_reg_write_q, exm_reg_write_d;
  logic                  exm_mem_read_q,  exm_mem_read_d;
  logic                  exm_mem_write_q, exm_mem_write_d;
  logic [XLEN-1:0]       exm_alu_q,       exm_alu_d;
  logic [XLEN-1:0]       exm_store_q,     exm_store_d;

  // MEM/WB entry
  logic                  wb_reg_write_q,  wb_reg_write_d;
  logic [REG_ADDR_W-1:0] wb_rd_q,         wb_rd_d;
  logic [XLEN-1:0]       wb_data_q,       wb_data_d;

  logic ex_is_mem;
  logic exm_is_mem;
  logic mem_req;
  logic mem_done;
  logic stall;
  logic advance;
  logic complete;

  // Handshake decode: a request is only live in StAccess, so a stray ack is ignored.
  always_comb begin
    ex_is_mem  = ex_valid & (ex_mem_read | ex_mem_write);
    exm_is_mem = exm_valid_q & (exm_mem_read_q | exm_mem_write_q);
    mem_req    = exm_is_mem & (state_q == StAccess);
    mem_done   = mem_req & dmem.dmem_ack;
    stall      = mem_req & ~dmem.dmem_ack;
    advance    = ~stall;
    complete   = exm_valid_q & (~exm_is_mem | mem_done);
    // Reset overrides the stall so EX sees ready during the reset cycle.
    ex_ready   = rst | advance;
  end

  // FSM next state: enter StAccess with each latched memory op, leave on ack.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (ex_is_mem) state_d = StAccess;
      end
      StAccess: begin
        // Back-to-back memory ops stay in StAccess for the newly latched entry.
        if (dmem.dmem_ack) state_d = ex_is_mem ? StAccess : StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // EX/MEM next state: load EX on advance, hold while the memory op is pending.
  always_comb begin
    exm_valid_d     = exm_valid_q;
    exm_rd_d        = exm_rd_q;
    exm_reg_write_d = exm_reg_write_q;
    exm_mem_read_d  = exm_mem_read_q;
    exm_mem_write_d = exm_mem_write_q;
    exm_alu_d       = exm_alu_q;
    exm_store_d     = exm_store_q;
    if (advance) begin
      exm_valid_d     = ex_valid;
      exm_rd_d        = ex_rd;
      exm_reg_write_d = ex_reg_write;
      // Bubbles never carry memory intent into the handshake.
      exm_mem_read_d  = ex_valid & ex_mem_read;
      exm_mem_write_d = ex_valid & ex_mem_write & ~ex_mem_read;
      exm_alu_d       = ex_alu_result;
      exm_store_d     = ex_store_data;
    end
  end

  // MEM/WB next state: capture a completing entry, otherwise insert a bubble.
  always_comb begin
    wb_reg_write_d = 1'b0;
    wb_rd_d        = '0;
    wb_data_d      = '0;
    if (complete) begin
      wb_reg_write_d = exm_reg_write_q & ~exm_mem_write_q & (exm_rd_q != '0);
      wb_rd_d        = exm_rd_q;
      wb_data_d      = exm_mem_read_q ? dmem.dmem_rdata : exm_alu_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // EX/MEM pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      exm_valid_q     <= 1'b0;
      exm_rd_q        <= '0;
      exm_reg_write_q <= 1'b0;
      exm_mem_read_q  <= 1'b0;
      exm_mem_write_q <= 1'b0;
      exm_alu_q       <= '0;
      exm_store_q     <= '0;
    end else begin
      exm_valid_q     <= exm_valid_d;
      exm_rd_q        <= exm_rd_d;
      exm_reg_write_q <= exm_reg_write_d;
      exm_mem_read_q  <= exm_mem_read_d;
      exm_mem_write_q <= exm_mem_write_d;
      exm_alu_q       <= exm_alu_d;
      exm_store_q     <= exm_store_d;
    end
  end

  // MEM/WB pipeline register; reset drops any aborted access.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= '0;
      wb_data_q      <= '0;
    end else begin
      wb_reg_write_q <= wb_reg_write_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
    end
  end

  // Output drive: memory bus straight from EX/MEM, hazard taps and writeback port.
  always_comb begin
    dmem.dmem_req   = mem_req;
    dmem.dmem_we    = exm_mem_write_q;
    dmem.dmem_addr  = exm_alu_q;
    dmem.dmem_wdata = exm_store_q;

    EX_MEM_regWrite = exm_valid_q & exm_reg_write_q & (exm_rd_q != '0);
    EX_MEM_rd       = exm_rd_q;
    EX_MEM_fwd_data = exm_alu_q;

    MEM_WB_regWrite = wb_reg_write_q;
    MEM_WB_rd       = wb_rd_q;
    MEM_WB_data     = wb_data_q;
  end

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Bench for mem_stage_pipe: directed scenarios followed by random traffic, all
// checked cycle by cycle against a transaction-level model of the MEM stage.
module tb_mem_stage_pipe;

  typedef struct packed {
    logic        v;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [31:0] alu;
    logic [31:0] sd;
  } instr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic        ex_ready;
  logic        EX_MEM_regWrite;
  logic [4:0]  EX_MEM_rd;
  logic [31:0] EX_MEM_fwd_data;
  logic        MEM_WB_regWrite;
  logic [4:0]  MEM_WB_rd;
  logic [31:0] MEM_WB_data;

  int n_chk = 0;
  int n_err = 0;

  mem_stage_pipe_if #(.XLEN(32)) dmem_if ();

  mem_stage_pipe #(
    .XLEN       (32),
    .REG_ADDR_W (5)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ex_valid        (ex_valid),
    .ex_rd           (ex_rd),
    .ex_reg_write    (ex_reg_write),
    .ex_mem_read     (ex_mem_read),
    .ex_mem_write    (ex_mem_write),
    .ex_alu_result   (ex_alu_result),
    .ex_store_data   (ex_store_data),
    .ex_ready        (ex_ready),
    .dmem            (dmem_if.master),
    .EX_MEM_regWrite (EX_MEM_regWrite),
    .EX_MEM_rd       (EX_MEM_rd),
    .EX_MEM_fwd_data (EX_MEM_fwd_data),
    .MEM_WB_regWrite (MEM_WB_regWrite),
    .MEM_WB_rd       (MEM_WB_rd),
    .MEM_WB_data     (MEM_WB_data)
  );

  always #5 clk = ~clk;

  // Model state: the op currently in EX/MEM, its remaining wait cycles, and the
  // MEM/WB contents expected after the next edge.
  instr_t      m_exm;
  int          m_wait;
  logic        m_wb_rw;
  logic        m_wb_bub;
  logic [4:0]  m_wb_rd;
  logic [31:0] m_wb_data;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
    return {a[15:0], a[31:16]} ^ 32'h3C5A_96E1;
  endfunction

  function automatic instr_t mk(input logic v, input logic [4:0] rd, input logic rw,
                                input logic mr, input logic mw, input logic [31:0] alu,
                                input logic [31:0] sd);
    instr_t t;
    t.v = v; t.rd = rd; t.rw = rw; t.mr = mr; t.mw = mw; t.alu = alu; t.sd = sd;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_exm     = '0;
    m_wait    = 0;
    m_wb_rw   = 1'b0;
    m_wb_bub  = 1'b1;
    m_wb_rd   = '0;
    m_wb_data = '0;
  endtask

  // One clock cycle: check registered outputs, present ins (and rst), play the
  // memory side, check ex_ready, then advance the model across the next edge.
  task automatic run_cycle(input instr_t ins, input int lat, input bit r, output bit took);
    logic exp_req;
    logic exp_rdy;
    logic done;
    @(negedge clk);
    exp_req = m_exm.v & (m_exm.mr | m_exm.mw);
    chk("ex_mem_regwrite", EX_MEM_regWrite, m_exm.v & m_exm.rw & (m_exm.rd != 5'd0));
    if (m_exm.v) begin
      chk("ex_mem_rd", EX_MEM_rd, m_exm.rd);
      chk("ex_mem_fwd", EX_MEM_fwd_data, m_exm.alu);
    end
    chk("dmem_req", dmem_if.dmem_req, exp_req);
    if (exp_req) begin
      chk("dmem_we", dmem_if.dmem_we, m_exm.mw);
      chk("dmem_addr", dmem_if.dmem_addr, m_exm.alu);
      if (m_exm.mw) chk("dmem_wdata", dmem_if.dmem_wdata, m_exm.sd);
    end
    chk("mem_wb_regwrite", MEM_WB_regWrite, m_wb_rw);
    if (m_wb_rw || m_wb_bub) begin
      chk("mem_wb_rd", MEM_WB_rd, m_wb_rd);
      chk("mem_wb_data", MEM_WB_data, m_wb_data);
    end

    rst           = r;
    ex_valid      = ins.v;
    ex_rd         = ins.rd;
    ex_reg_write  = ins.rw;
    ex_mem_read   = ins.mr;
    ex_mem_write  = ins.mw;
    ex_alu_result = ins.alu;
    ex_store_data = ins.sd;
    // Stray acks while no request is outstanding must be ignored.
    dmem_if.dmem_ack   = exp_req ? (m_wait == 0) : 1'($urandom_range(1, 0));
    dmem_if.dmem_rdata = (exp_req && m_wait == 0) ? mem_word(m_exm.alu) : $urandom;
    #1;
    exp_rdy = r || !(exp_req && m_wait != 0);
    chk("ex_ready", ex_ready, exp_rdy);

    took = 1'b0;
    if (r) begin
      model_reset();
    end else begin
      done      = m_exm.v && (!(m_exm.mr || m_exm.mw) || m_wait == 0);
      m_wb_bub  = !done;
      m_wb_rw   = done && m_exm.rw && !m_exm.mw && (m_exm.rd != 5'd0);
      m_wb_rd   = done ? m_exm.rd : 5'd0;
      m_wb_data = !done ? 32'd0 : (m_exm.mr ? mem_word(m_exm.alu) : m_exm.alu);
      if (exp_req && m_wait != 0) m_wait--;
      if (exp_rdy) begin
        m_exm  = ins;
        m_wait = lat;
        took   = 1'b1;
      end
    end
  endtask

  instr_t bub;
  instr_t pend;
  bit     took;
  bit     have;
  bit     rs;
  int     lat;
  int     cnt_stall;
  int     cnt_wb;
  int     cnt_req;
  int     kind;

  initial begin
    bub                = '0;
    rst                = 1'b1;
    ex_valid           = 1'b1;
    ex_rd              = 5'd1;
    ex_reg_write       = 1'b1;
    ex_mem_read        = 1'b0;
    ex_mem_write       = 1'b0;
    ex_alu_result      = 32'h1234;
    ex_store_data      = 32'h0;
    dmem_if.dmem_ack   = 1'b0;
    dmem_if.dmem_rdata = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);

    // 1: reset held with a valid op at the input.
    run_cycle(mk(1, 5'd4, 1, 0, 0, 32'h55, 32'h0), 0, 1'b1, took);
    run_cycle(mk(1, 5'd4, 1, 1, 0, 32'h100, 32'h0), 0, 1'b1, took);
    chk("t1_ready", ex_ready, 1'b1);
    chk("t1_req", dmem_if.dmem_req, 1'b0);
    chk("t1_wb", MEM_WB_regWrite, 1'b0);

    // 2: plain ALU op.
    run_cycle(mk(1, 5'd5, 1, 0, 0, 32'h10, 32'h0), 0, 1'b0, took);
    run_cycle(bub, 0, 1'b0, took);
    chk("t2_exm_rw", EX_MEM_regWrite, 1'b1);
    chk("t2_exm_rd", EX_MEM_rd, 5'd5);
    chk("t2_exm_fwd", EX_MEM_fwd_data, 32'h10);
    run_cycle(bub, 0, 1'b0, took);
    chk("t2_wb_rw", MEM_WB_regWrite, 1'b1);
    chk("t2_wb_rd", MEM_WB_rd, 5'd5);
    chk("t2_wb_data", MEM_WB_data, 32'h10);
    run_cycle(bub, 0, 1'b0, took);
    chk("t2_wb_once", MEM_WB_regWrite, 1'b0);

    // 3: load with three wait cycles.
    run_cycle(mk(1, 5'd7, 1, 1, 0, 32'h100, 32'h0), 3, 1'b0, took);
    cnt_stall = 0;
    cnt_wb    = 0;
    for (int i = 0; i < 7; i++) begin
      run_cycle(bub, 0, 1'b0, took);
      if (!ex_ready) cnt_stall++;
      if (MEM_WB_regWrite) begin
        cnt_wb++;
        chk("t3_wb_rd", MEM_WB_rd, 5'd7);
        chk("t3_wb_data", MEM_WB_data, 32'hDEAD_BEEF);
      end
    end
    chk("t3_stall_cycles", cnt_stall, 3);
    chk("t3_wb_count", cnt_wb, 1);

    // 4: store with zero-wait ack.
    run_cycle(mk(1, 5'd9, 0, 0, 1, 32'h200, 32'hCAFE), 0, 1'b0, took);
    cnt_req = 0;
    cnt_wb  = 0;
    for (int i = 0; i < 4; i++) begin
      run_cycle(bub, 0, 1'b0, took);
      if (dmem_if.dmem_req) begin
        cnt_req++;
        chk("t4_we", dmem_if.dmem_we, 1'b1);
        chk("t4_wdata", dmem_if.dmem_wdata, 32'hCAFE);
      end
      if (MEM_WB_regWrite) cnt_wb++;
    end
    chk("t4_req_cycles", cnt_req, 1);
    chk("t4_no_wb", cnt_wb, 0);

    // 5: ALU op targeting x0.
    run_cycle(mk(1, 5'd0, 1, 0, 0, 32'h77, 32'h0), 0, 1'b0, took);
    run_cycle(bub, 0, 1'b0, took);
    chk("t5_exm_rw", EX_MEM_regWrite, 1'b0);
    run_cycle(bub, 0, 1'b0, took);
    chk("t5_wb_rw", MEM_WB_regWrite, 1'b0);

    // 6: reset during the second wait cycle of a load.
    run_cycle(mk(1, 5'd3, 1, 1, 0, 32'h340, 32'h0), 5, 1'b0, took);
    run_cycle(bub, 0, 1'b0, took);
    run_cycle(bub, 0, 1'b1, took);
    chk("t6_ready_in_rst", ex_ready, 1'b1);
    run_cycle(bub, 0, 1'b0, took);
    chk("t6_req_dropped", dmem_if.dmem_req, 1'b0);
    chk("t6_ready", ex_ready, 1'b1);
    cnt_wb = 0;
    for (int i = 0; i < 6; i++) begin
      run_cycle(bub, 0, 1'b0, took);
      if (MEM_WB_regWrite) cnt_wb++;
    end
    chk("t6_no_wb", cnt_wb, 0);

    // Random traffic; an op is held at the EX side until it is taken.
    have = 1'b0;
    lat  = 0;
    for (int i = 0; i < 600; i++) begin
      if (!have) begin
        kind = int'($urandom_range(3, 0));
        pend = mk(kind != 0, ($urandom_range(3, 0) == 0) ? 5'd0 : 5'($urandom_range(31, 0)),
                  kind == 1 || kind == 2, kind == 2, kind == 3, $urandom, $urandom);
        lat  = int'($urandom_range(3, 0));
        have = 1'b1;
      end
      rs = ($urandom_range(63, 0) == 0);
      run_cycle(pend, lat, rs, took);
      if (took || rs) have = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
